// File: rtl/mips_pc_pkg.sv
// mips_pc_pkg: shared types and constants for the MIPS PC sequencer.
//   pc_state_e   - sequencer FSM states
//   PC_WIDTH     - program counter width in bits
//   PC_STEP      - sequential fetch increment in bytes
//   RESET_VECTOR - default PC after reset
//   jump_target  - builds a J-type target from PC+4 and the index field
package mips_pc_pkg;

    localparam int unsigned PC_WIDTH = 32;
    localparam int unsigned PC_STEP  = 4;
    localparam logic [PC_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StRedirect
    } pc_state_e;

    // J-type target keeps the top nibble of the delay-slot PC.
    function automatic logic [PC_WIDTH-1:0] jump_target(
        input logic [PC_WIDTH-1:0] pc_plus4,
        input logic [25:0]         index
    );
        return {pc_plus4[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: groups the redirect inputs and the instruction-fetch handshake.
//   stall, branch, zero, jump, br_pc_next, branch_imm, jump_index - from hazard/branch logic
//   if_ack                                 - from instruction memory
//   if_req, pc, pc_next, fetch_done, flush - from the sequencer
// Modports: master = the PC sequencer, slave = the surrounding pipeline/memory.
interface pc_sequencer_if;
    import mips_pc_pkg::*;

    logic                stall;
    logic                branch;
    logic                zero;
    logic                jump;
    logic [PC_WIDTH-1:0] br_pc_next;
    logic [PC_WIDTH-1:0] branch_imm;
    logic [25:0]         jump_index;
    logic                if_ack;
    logic                if_req;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_next;
    logic                fetch_done;
    logic                flush;

    modport master (
        input  stall, branch, zero, jump, br_pc_next, branch_imm, jump_index, if_ack,
        output if_req, pc, pc_next, fetch_done, flush
    );

    modport slave (
        output stall, branch, zero, jump, br_pc_next, branch_imm, jump_index, if_ack,
        input  if_req, pc, pc_next, fetch_done, flush
    );

endinterface

// File: rtl/pc_adder.sv
// pc_adder: 32-bit branch target adder, wraps modulo 2^32.
//   pc_plus4  - PC+4 of the branch instruction
//   shift_out - word offset already shifted to bytes
//   sum       - branch target
module pc_adder
    import mips_pc_pkg::*;
(
    input  logic [PC_WIDTH-1:0] pc_plus4,
    input  logic [PC_WIDTH-1:0] shift_out,
    output logic [PC_WIDTH-1:0] sum
);

    assign sum = pc_plus4 + shift_out;

endmodule

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational redirect decode and target selection.
//   branch, zero, jump - resolving control-flow instruction
//   br_pc_next         - PC+4 of that instruction
//   branch_imm         - sign-extended word offset
//   jump_index         - J-type index field
//   redirect           - a taken branch or a jump is present
//   target             - selected redirect target (jump wins over branch)
module pc_target_calc
    import mips_pc_pkg::*;
(
    input  logic                branch,
    input  logic                zero,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] br_pc_next,
    input  logic [PC_WIDTH-1:0] branch_imm,
    input  logic [25:0]         jump_index,
    output logic                redirect,
    output logic [PC_WIDTH-1:0] target
);

    logic [PC_WIDTH-1:0] shift_out;
    logic [PC_WIDTH-1:0] branch_target;
    logic                unused_imm_hi;

    // The top two offset bits fall off the word-to-byte shift.
    assign shift_out     = {branch_imm[29:0], 2'b00};
    assign unused_imm_hi = ^branch_imm[31:30];

    pc_adder u_pc_adder (
        .pc_plus4  (br_pc_next),
        .shift_out (shift_out),
        .sum       (branch_target)
    );

    assign redirect = jump | (branch & zero);
    assign target   = jump ? jump_target(br_pc_next, jump_index) : branch_target;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC and the instruction-fetch handshake of the MIPS core.
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - pc_sequencer_if.master: redirect inputs, stall, fetch handshake,
//           pc / pc_next, fetch_done and flush pulses
// Redirects seen while a fetch is outstanding are parked in a pending register
// and applied when the in-flight (wrong-path) fetch completes.
module pc_sequencer
    import mips_pc_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] ResetVector = RESET_VECTOR,
    parameter int unsigned         PcStep      = PC_STEP
) (
    input logic                  clk,
    input logic                  rst_n,
    pc_sequencer_if.master       bus
);

    localparam logic [PC_WIDTH-1:0] Step = PC_WIDTH'(PcStep);

    pc_state_e           state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] pend_q, pend_d;
    logic                outst_q, outst_d;

    logic                redirect;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] pc_inc;
    logic                if_req;
    logic                fetch_done;
    logic                flush;

    pc_target_calc u_target_calc (
        .branch     (bus.branch),
        .zero       (bus.zero),
        .jump       (bus.jump),
        .br_pc_next (bus.br_pc_next),
        .branch_imm (bus.branch_imm),
        .jump_index (bus.jump_index),
        .redirect   (redirect),
        .target     (target)
    );

    assign pc_inc = pc_q + Step;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        outst_d    = outst_q;
        if_req     = 1'b0;
        fetch_done = 1'b0;
        flush      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Any late ack from before reset is dropped here.
                state_d = StFetch;
            end

            StFetch: begin
                if_req = !(bus.stall && !outst_q);
                if (bus.if_ack) begin
                    outst_d = 1'b0;
                    if (redirect) begin
                        pc_d  = target;
                        flush = 1'b1;
                    end else if (!bus.stall) begin
                        pc_d       = pc_inc;
                        fetch_done = 1'b1;
                    end
                end else if (redirect) begin
                    if (outst_q) begin
                        pend_d  = target;
                        state_d = StRedirect;
                    end else begin
                        // A request raised only this cycle is withdrawn with the old PC.
                        pc_d    = target;
                        flush   = 1'b1;
                        outst_d = 1'b0;
                    end
                end else begin
                    outst_d = if_req;
                end
            end

            StRedirect: begin
                if_req = 1'b1;
                if (bus.if_ack) begin
                    // A redirect coinciding with the ack is the most recent one.
                    pc_d    = redirect ? target : pend_q;
                    flush   = 1'b1;
                    outst_d = 1'b0;
                    state_d = StFetch;
                end else if (redirect) begin
                    pend_d = target;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= {ResetVector[PC_WIDTH-1:2], 2'b00};
            pend_q  <= '0;
            outst_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= {pc_d[PC_WIDTH-1:2], 2'b00};
            pend_q  <= pend_d;
            outst_q <= outst_d;
        end
    end

    assign bus.if_req     = if_req;
    assign bus.pc         = pc_q;
    assign bus.pc_next    = pc_inc;
    assign bus.fetch_done = fetch_done;
    assign bus.flush      = flush;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table, hand-written redirect/reset sequences,
// then randomized traffic checked against a behavioural PC model.
module tb_pc_sequencer;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .ResetVector (32'h0000_0000),
        .PcStep      (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        branch;
        logic        zero;
        logic        jump;
        logic [31:0] bpc;
        logic [31:0] imm;
        logic [25:0] jidx;
        logic        ack;
        logic        req;
        logic [31:0] pc;
        logic        done;
        logic        fl;
    } vec_t;

    function automatic vec_t mk(logic st, logic br, logic z, logic j, logic [31:0] bpc,
                                logic [31:0] imm, logic [25:0] jidx, logic ack,
                                logic req, logic [31:0] pc, logic done, logic fl);
        vec_t v;
        v.stall = st; v.branch = br; v.zero = z; v.jump = j;
        v.bpc = bpc; v.imm = imm; v.jidx = jidx; v.ack = ack;
        v.req = req; v.pc = pc; v.done = done; v.fl = fl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.stall      = v.stall;
        bus.branch     = v.branch;
        bus.zero       = v.zero;
        bus.jump       = v.jump;
        bus.br_pc_next = v.bpc;
        bus.branch_imm = v.imm;
        bus.jump_index = v.jidx;
        bus.if_ack     = v.ack;
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        chk({tag, ".if_req"},     32'(bus.if_req),     32'(v.req));
        chk({tag, ".pc"},         bus.pc,              v.pc);
        chk({tag, ".pc_next"},    bus.pc_next,         v.pc + 32'd4);
        chk({tag, ".fetch_done"}, 32'(bus.fetch_done), 32'(v.done));
        chk({tag, ".flush"},      32'(bus.flush),      32'(v.fl));
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic apply(input string tag, input vec_t v);
        drive(v);
        #1;
        check_outs(tag, v);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Behavioural model state
    bit          m_started;
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    bit          m_pend_v;
    bit          m_outst;

    vec_t vecs[24];
    vec_t seqs[6];

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // stall br z j  bpc  imm  jidx  ack | req pc done flush
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0, 1, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h4, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h4, 1, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h8, 1, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hC, 0, 0);
        vecs[8]  = mk(0, 1, 1, 0, 32'h10, 32'h44, 0, 1, 1, 32'hC, 0, 1);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h120, 0, 0);
        vecs[10] = mk(0, 1, 0, 0, 32'h10, 32'h44, 0, 1, 1, 32'h120, 1, 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h124, 0, 0);
        vecs[12] = mk(0, 1, 1, 1, 32'h4000_0004, 32'h44, 26'h100, 1, 1, 32'h124, 0, 1);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h4000_0400, 0, 0);
        vecs[14] = mk(0, 0, 0, 1, 32'h4, 0, 26'h8, 1, 1, 32'h4000_0400, 0, 1);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h20, 0, 0);
        vecs[16] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h20, 0, 0);
        vecs[17] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h20, 0, 0);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h20, 0, 0);
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h20, 1, 0);
        vecs[20] = mk(0, 0, 0, 1, 32'hF000_0000, 0, 26'h3FF_FFFF, 1, 1, 32'h24, 0, 1);
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hFFFF_FFFC, 1, 0);
        vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0);

        // Redirects parked behind an outstanding fetch; last one wins.
        seqs[0] = mk(0, 1, 1, 0, 32'h100, 32'h10, 0, 0, 1, 32'h0, 0, 0);
        seqs[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0);
        seqs[2] = mk(0, 0, 0, 1, 32'h0, 0, 26'h40, 0, 1, 32'h0, 0, 0);
        seqs[3] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0, 0, 1);
        seqs[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0);
        seqs[5] = mk(0, 1, 1, 0, 32'h200, 32'h1, 0, 0, 1, 32'h100, 0, 0);

        // Reset values while held in reset
        rst_n = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        check_outs("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) apply($sformatf("vec%0d", i), vecs[i]);
        for (int i = 0; i < 6; i++) apply($sformatf("seq%0d", i), seqs[i]);

        // Now in the redirect-pending state: reset asynchronously mid-cycle.
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        #3;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 0));
        @(negedge clk);
        check_outs("in_rst", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 0));
        rst_n = 1'b1;
        apply("idle_stray_ack", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 0));
        apply("post_rst_req",   mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0));
        apply("post_rst_ack",   mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0, 1, 0));

        // Randomized traffic against the model
        do_reset();
        m_started = 0;
        m_pc      = 32'h0;
        m_pend    = 32'h0;
        m_pend_v  = 0;
        m_outst   = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            vec_t        v;
            logic [31:0] r;
            logic [31:0] tgt;
            bit          redir;
            int          s;

            v.stall  = ($urandom_range(0, 3) == 0);
            v.branch = ($urandom_range(0, 3) == 0);
            v.zero   = $urandom_range(0, 1) == 1;
            v.jump   = ($urandom_range(0, 7) == 0);
            r        = $urandom();
            v.bpc    = {r[31:2], 2'b00};
            s        = int'($urandom_range(0, 64)) - 32;
            v.imm    = $urandom_range(0, 1) == 1 ? 32'(s) : $urandom();
            r        = $urandom();
            v.jidx   = r[25:0];

            // Expected outputs from the model
            if (!m_started)    v.req = 0;
            else if (m_pend_v) v.req = 1;
            else               v.req = !(v.stall && !m_outst);
            v.ack  = v.req && ($urandom_range(0, 2) == 0);
            v.pc   = m_pc;
            v.done = 0;
            v.fl   = 0;

            redir = v.jump || (v.branch && v.zero);
            tgt   = v.jump ? {v.bpc[31:28], v.jidx, 2'b00} : v.bpc + (v.imm << 2);

            if (!m_started) begin
                m_started = 1;
            end else if (m_pend_v) begin
                if (v.ack) begin
                    m_pc     = redir ? tgt : m_pend;
                    v.fl     = 1;
                    m_pend_v = 0;
                    m_outst  = 0;
                end else if (redir) begin
                    m_pend = tgt;
                end
            end else if (v.ack) begin
                m_outst = 0;
                if (redir) begin
                    m_pc = tgt;
                    v.fl = 1;
                end else if (!v.stall) begin
                    m_pc   = m_pc + 32'd4;
                    v.done = 1;
                end
            end else if (redir) begin
                if (m_outst) begin
                    m_pend   = tgt;
                    m_pend_v = 1;
                end else begin
                    m_pc = tgt;
                    v.fl = 1;
                end
            end else begin
                m_outst = v.req;
            end

            apply($sformatf("rand%0d", cyc), v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
